// File: rtl/traceback_walker_if.sv
// traceback_walker_if: start/result, direction-read and path-op signals of the traceback walker
interface traceback_walker_if #(
  parameter int ROW_W   = 8,
  parameter int COL_W   = 8,
  parameter int SCORE_W = 10,
  parameter int PATH_W  = 10
);
  logic               start;
  logic               abort;
  logic [SCORE_W-1:0] max_score;
  logic [ROW_W-1:0]   max_row;
  logic [COL_W-1:0]   max_col;
  logic               rd_req;
  logic [ROW_W-1:0]   rd_row;
  logic [COL_W-1:0]   rd_col;
  logic               rd_valid;
  logic [1:0]         rd_dir;
  logic               op_valid;
  logic               op_ready;
  logic [1:0]         op_code;
  logic [ROW_W-1:0]   op_row;
  logic [COL_W-1:0]   op_col;
  logic               busy;
  logic               done;
  logic [PATH_W-1:0]  path_len;
  modport master (
    input  start, abort, max_score, max_row, max_col, rd_valid, rd_dir, op_ready,
    output rd_req, rd_row, rd_col, op_valid, op_code, op_row, op_col, busy, done, path_len
  );
  modport slave (
    output start, abort, max_score, max_row, max_col, rd_valid, rd_dir, op_ready,
    input  rd_req, rd_row, rd_col, op_valid, op_code, op_row, op_col, busy, done, path_len
  );
endinterface

// File: rtl/traceback_walker.sv
// traceback_walker: walks the direction matrix back from the max cell, streaming one op per cell
module traceback_walker #(
  parameter int ROW_W   = 8,
  parameter int COL_W   = 8,
  parameter int SCORE_W = 10,
  parameter int PATH_W  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  traceback_walker_if.master bus
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, EMIT, DONE} state_t;
  state_t           state, state_nx;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  logic             zero_score, hs, mv_row, mv_col, edge_hit;
  assign zero_score = bus.max_score == SCORE_W'(0);
  assign hs         = state == EMIT && bus.op_ready;
  // op_code only holds DIAG/UP/LEFT here: UP never moves the column, LEFT never the row
  assign mv_row     = bus.op_code != 2'b11;
  assign mv_col     = bus.op_code != 2'b10;
  assign edge_hit   = (mv_row && cur_row == '0) || (mv_col && cur_col == '0);
  assign bus.rd_req   = state == READ;
  assign bus.rd_row   = cur_row;
  assign bus.rd_col   = cur_col;
  assign bus.op_valid = state == EMIT;
  assign bus.busy     = state != IDLE;
  assign bus.done     = state == DONE;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = bus.start ? (zero_score ? DONE : READ) : IDLE;
      READ:    state_nx = WAIT;
      WAIT:    state_nx = !bus.rd_valid ? WAIT : (bus.rd_dir == 2'b00 ? DONE : EMIT);
      EMIT:    state_nx = !bus.op_ready ? EMIT : (edge_hit ? DONE : READ);
      default: state_nx = IDLE;
    endcase
    if (bus.abort) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cur_row      <= '0;
      cur_col      <= '0;
      bus.op_code  <= '0;
      bus.op_row   <= '0;
      bus.op_col   <= '0;
      bus.path_len <= '0;
    end else begin
      state <= state_nx;
      if (!bus.abort) begin
        if (state == IDLE && bus.start) begin
          bus.path_len <= '0;
          if (!zero_score) begin
            cur_row <= bus.max_row;
            cur_col <= bus.max_col;
          end
        end
        if (state == WAIT && bus.rd_valid && bus.rd_dir != 2'b00) begin
          bus.op_code <= bus.rd_dir;
          bus.op_row  <= cur_row;
          bus.op_col  <= cur_col;
        end
        if (hs) begin
          bus.path_len <= bus.path_len + PATH_W'(!(&bus.path_len));
          if (!edge_hit) begin
            cur_row <= cur_row - ROW_W'(mv_row);
            cur_col <= cur_col - COL_W'(mv_col);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_traceback_walker.sv
// tb_traceback_walker: table-driven walks with an op scoreboard, plus abort and reset sequences
module tb_traceback_walker;
  localparam logic [1:0] STOP = 2'd0, DIAG = 2'd1, UP = 2'd2, LEFT = 2'd3;
  typedef struct {
    logic [9:0]      score;
    logic [7:0]      row;
    logic [7:0]      col;
    logic [4:0][1:0] dirs;
    int              stall;
    int              lat;
    int              len;
    int              nreq;
  } vec_t;
  typedef struct {
    logic [1:0] code;
    logic [7:0] row;
    logic [7:0] col;
  } op_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  op_t  q[$];
  vec_t tbl [5];
  traceback_walker_if bus ();
  traceback_walker dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, {bus.rd_req, bus.op_valid, bus.busy, bus.done}, 0);
    chk({tag, "_rd_addr"}, {bus.rd_row, bus.rd_col}, 0);
    chk({tag, "_op_fields"}, {bus.op_code, bus.op_row, bus.op_col}, 0);
    chk({tag, "_path_len"}, bus.path_len, 0);
  endtask
  task automatic run_vec(input int idx, input vec_t v);
    int  mrow, mcol, cnt, st, nreq, nhs, di, exp_done, exp_rd;
    bit  fin;
    op_t e;
    q.delete();
    @(negedge clk);
    bus.start = 1'b1;
    bus.max_score = v.score;
    bus.max_row = v.row;
    bus.max_col = v.col;
    mrow = v.row;
    mcol = v.col;
    exp_rd = (v.score == 0) ? -1 : 1;
    exp_done = (v.score == 0) ? 1 : -1;
    cnt = 0; st = 0; nreq = 0; nhs = 0; di = 0; fin = 1'b0;
    for (int cyc = 1; cyc < 400 && !fin; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.rd_valid = 1'b0;
      bus.op_ready = 1'b0;
      if (cyc == 1) chk($sformatf("v%0d_busy_c1", idx), bus.busy, 1);
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.rd_valid = 1'b1;
          bus.rd_dir = v.dirs[di];
          if (v.dirs[di] == STOP) exp_done = cyc + 1;
          else q.push_back('{v.dirs[di], 8'(mrow), 8'(mcol)});
          di++;
        end
      end
      if (bus.rd_req) begin
        chk($sformatf("v%0d_rd_cycle", idx), cyc, exp_rd);
        chk($sformatf("v%0d_rd_row", idx), bus.rd_row, mrow);
        chk($sformatf("v%0d_rd_col", idx), bus.rd_col, mcol);
        exp_rd = -1;
        nreq++;
        cnt = v.lat + 1;
      end
      if (bus.op_valid) begin
        if (q.size() == 0) chk($sformatf("v%0d_op_unexpected", idx), 1, 0);
        else begin
          chk($sformatf("v%0d_op_code", idx), bus.op_code, q[0].code);
          chk($sformatf("v%0d_op_row", idx), bus.op_row, q[0].row);
          chk($sformatf("v%0d_op_col", idx), bus.op_col, q[0].col);
          if (st < v.stall) st++;
          else begin
            bus.op_ready = 1'b1;
            e = q.pop_front();
            st = 0;
            nhs++;
            if ((e.code != LEFT && mrow == 0) || (e.code != UP && mcol == 0)) exp_done = cyc + 1;
            else begin
              if (e.code != LEFT) mrow--;
              if (e.code != UP) mcol--;
              exp_rd = cyc + 1;
            end
          end
        end
      end
      if (bus.done) begin
        chk($sformatf("v%0d_done_cycle", idx), cyc, exp_done);
        chk($sformatf("v%0d_busy_at_done", idx), bus.busy, 1);
        fin = 1'b1;
      end
    end
    if (!fin) chk($sformatf("v%0d_timeout_no_done", idx), 0, 1);
    chk($sformatf("v%0d_path_len", idx), bus.path_len, v.len);
    chk($sformatf("v%0d_rd_req_count", idx), nreq, v.nreq);
    chk($sformatf("v%0d_handshakes", idx), nhs, v.len);
    chk($sformatf("v%0d_ops_left", idx), q.size(), 0);
    @(negedge clk);
    chk($sformatf("v%0d_after_done", idx), {bus.done, bus.busy, bus.rd_req, bus.op_valid}, 0);
  endtask
  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.max_score = '0; bus.max_row = '0; bus.max_col = '0;
    bus.rd_valid = 1'b0; bus.rd_dir = STOP; bus.op_ready = 1'b0;
    tbl[0] = '{10'd7,  8'd5, 8'd4, {STOP, STOP, DIAG, DIAG, DIAG}, 0, 0, 3, 4};
    tbl[1] = '{10'd9,  8'd3, 8'd3, {STOP, STOP, STOP, LEFT, UP},   4, 0, 2, 3};
    tbl[2] = '{10'd0,  8'd3, 8'd3, {STOP, STOP, STOP, STOP, STOP}, 0, 0, 0, 0};
    tbl[3] = '{10'd5,  8'd0, 8'd2, {STOP, STOP, STOP, STOP, DIAG}, 0, 0, 1, 1};
    tbl[4] = '{10'd12, 8'd4, 8'd1, {STOP, STOP, LEFT, UP, LEFT},   1, 2, 3, 3};
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("idle");
    for (int i = 0; i < 5; i++) run_vec(i, tbl[i]);
    // abort while waiting for read data; the late rd_valid must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.max_score = 10'd4; bus.max_row = 8'd5; bus.max_col = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    chk("abw_rd_req", bus.rd_req, 1);
    @(negedge clk);
    chk("abw_busy_wait", bus.busy, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abw_idle", {bus.busy, bus.rd_req, bus.done, bus.op_valid}, 0);
    bus.rd_valid = 1'b1; bus.rd_dir = DIAG;
    @(negedge clk);
    bus.rd_valid = 1'b0;
    chk("abw_late_valid", {bus.op_valid, bus.busy}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abw_no_done", {bus.done, bus.busy}, 0);
    end
    chk("abw_path_len", bus.path_len, 0);
    // abort while the second op is waiting for ready; partial count stays
    @(negedge clk);
    bus.start = 1'b1; bus.max_score = 10'd6; bus.max_row = 8'd6; bus.max_col = 8'd6;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.rd_valid = 1'b1; bus.rd_dir = DIAG;
    @(negedge clk);
    bus.rd_valid = 1'b0;
    chk("abe_op1_valid", bus.op_valid, 1);
    bus.op_ready = 1'b1;
    @(negedge clk);
    bus.op_ready = 1'b0;
    chk("abe_rd_row2", bus.rd_row, 5);
    @(negedge clk);
    bus.rd_valid = 1'b1; bus.rd_dir = DIAG;
    @(negedge clk);
    bus.rd_valid = 1'b0;
    chk("abe_op2_valid", bus.op_valid, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abe_idle", {bus.op_valid, bus.busy, bus.done, bus.rd_req}, 0);
    chk("abe_path_len", bus.path_len, 1);
    @(negedge clk);
    chk("abe_no_done", {bus.done, bus.busy}, 0);
    run_vec(10, tbl[0]);
    // start pulses while busy are ignored, then reset lands mid-EMIT
    @(negedge clk);
    bus.start = 1'b1; bus.max_score = 10'd7; bus.max_row = 8'd5; bus.max_col = 8'd4;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rst_rd_row", bus.rd_row, 5);
    @(negedge clk);
    bus.rd_valid = 1'b1; bus.rd_dir = DIAG;
    @(negedge clk);
    bus.rd_valid = 1'b0;
    chk("rst_op_valid", bus.op_valid, 1);
    bus.start = 1'b1; bus.max_score = 10'd3; bus.max_row = 8'd9; bus.max_col = 8'd9;
    @(negedge clk);
    bus.start = 1'b0;
    chk("ign_op_pos", {bus.op_row, bus.op_col}, {8'd5, 8'd4});
    bus.op_ready = 1'b1;
    @(negedge clk);
    bus.op_ready = 1'b0;
    chk("ign_rd_req", bus.rd_req, 1);
    chk("ign_rd_pos", {bus.rd_row, bus.rd_col}, {8'd4, 8'd3});
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("ign_wait_pos", {bus.rd_row, bus.rd_col}, {8'd4, 8'd3});
    bus.rd_valid = 1'b1; bus.rd_dir = UP;
    @(negedge clk);
    bus.rd_valid = 1'b0;
    chk("rst_op2", {bus.op_valid, bus.op_code, bus.op_row, bus.op_col}, {1'b1, UP, 8'd4, 8'd3});
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("post_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
